// File: rtl/packet_fifo_arbiter.sv
// packet_fifo_arbiter
// Round-robin arbiter that shares one packet_to_fifo instance between pNumReq packet
// sources. The winner's packet is latched and pushed with a one-cycle write strobe. The
// arbiter then waits for done, error or timeout and pulses a per-requester completion.
//
// Ports:
//   iClk        system clock
//   iRst        synchronous reset, active-low
//   iReq        level request per requester, held until its oDone/oErr
//   iReqData    packed packets, requester k at [k*PB +: PB]
//   oGrant      one-hot owner of the current transfer, 0 when idle
//   oDone       one-cycle pulse on the owner's bit: packet accepted
//   oErr        one-cycle pulse on the owner's bit: packet error or timeout
//   oPacketWr   one-cycle write strobe to packet_to_fifo
//   oPacketData latched packet, held until the next grant
//   iPacketDone completion from packet_to_fifo
//   iPacketErr  error from packet_to_fifo
//   oBusy       high whenever a transfer is in progress
module packet_fifo_arbiter #(
    parameter int unsigned pNumReq     = 2,
    parameter int unsigned pPacketSize = 64,
    parameter int unsigned pTimeout    = 1024
) (
    input  logic                              iClk,
    input  logic                              iRst,
    input  logic [pNumReq-1:0]                iReq,
    input  logic [pNumReq*pPacketSize*8-1:0]  iReqData,
    output logic [pNumReq-1:0]                oGrant,
    output logic [pNumReq-1:0]                oDone,
    output logic [pNumReq-1:0]                oErr,
    output logic                              oPacketWr,
    output logic [pPacketSize*8-1:0]          oPacketData,
    input  logic                              iPacketDone,
    input  logic                              iPacketErr,
    output logic                              oBusy
);

    localparam int unsigned PB   = pPacketSize * 8;
    localparam int unsigned CntW = $clog2(pTimeout);
    localparam int unsigned IdxW = (pNumReq > 1) ? $clog2(pNumReq) : 1;

    localparam logic [CntW-1:0] CntMax  = CntW'(pTimeout - 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(pNumReq - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [pNumReq-1:0] grant_q, grant_d;
    logic [pNumReq-1:0] done_q, done_d;
    logic [pNumReq-1:0] err_q, err_d;
    logic               wr_q, wr_d;
    logic [PB-1:0]      data_q, data_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic               busy_q, busy_d;

    logic               sel_found;
    logic [IdxW-1:0]    sel_idx;
    int unsigned        cand;

    // Search starts just after the previous winner and wraps, so the last owner has
    // lowest priority on the next round.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= pNumReq; i++) begin
            cand = (32'(last_q) + i) % pNumReq;
            if (!sel_found && iReq[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        wr_d    = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    last_d           = sel_idx;
                    data_d           = iReqData[32'(sel_idx)*PB +: PB];
                    wr_d             = 1'b1;
                    cnt_d            = '0;
                    state_d          = StWait;
                end
            end
            StWait: begin
                // Error wins over done; a done on the final count still counts as done.
                if (iPacketErr) begin
                    err_d   = grant_q;
                    state_d = StResp;
                end else if (iPacketDone) begin
                    done_d  = grant_q;
                    state_d = StResp;
                end else if (cnt_q == CntMax) begin
                    err_d   = grant_q;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q <= StIdle;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= LastRst;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign oGrant      = grant_q;
    assign oDone       = done_q;
    assign oErr        = err_q;
    assign oPacketWr   = wr_q;
    assign oPacketData = data_q;
    assign oBusy       = busy_q;

endmodule

// File: doc/packet_fifo_arbiter.md
# packet_fifo_arbiter

Round-robin arbiter that shares a single `packet_to_fifo` instance between `pNumReq` packet sources. It latches the winning requester's packet and issues a one-cycle write strobe to `packet_to_fifo`. It then waits for done, error or timeout and returns a per-requester completion pulse. It sits between the measurement/command packet producers and the `packet_to_fifo` → RAM FIFO path.

## Interface
- pNumReq, 2, number of requesters (2..8)
- pPacketSize, 64, packet size in bytes; must match the `packet_to_fifo` instance
- pTimeout, 1024, WAIT-state cycles before a missing done is declared an error (≥2)
- Derived: PB = pPacketSize*8; timeout counter width = $clog2(pTimeout)

- iClk  in  1  system clock
- iRst  in  1  synchronous reset, active-low (0 = reset, sampled on rising iClk)
- iReq  in  pNumReq  level request per requester; held until that requester's oDone/oErr
- iReqData  in  pNumReq*PB  packed packets; requester k at [k*PB +: PB]; stable while iReq[k]=1
- oGrant  out  pNumReq  one-hot owner of current transfer; 0 when idle
- oDone  out  pNumReq  one-cycle pulse on the owner's bit: packet accepted
- oErr  out  pNumReq  one-cycle pulse on the owner's bit: packet error or timeout
- oPacketWr  out  1  one-cycle strobe to packet_to_fifo iPacketWr
- oPacketData  out  PB  latched packet to packet_to_fifo iPacketData; held until next grant
- iPacketDone  in  1  from packet_to_fifo oPacketDone
- iPacketErr  in  1  from packet_to_fifo oErr
- oBusy  out  1  high whenever state ≠ IDLE

## Operation
- All outputs are registered.
- Reset (iRst=0): state=IDLE; oGrant, oDone, oErr, oPacketWr, oBusy, oPacketData = 0; timeout counter = 0; round-robin pointer rLast = pNumReq-1, so requester 0 has first priority.
- States: IDLE, WAIT, RESP.
- IDLE: if any iReq bit is set, select the first set bit searching from (rLast+1) mod pNumReq, wrapping. On that edge:
  - oGrant ← one-hot(sel), rLast ← sel
  - oPacketData ← iReqData[sel*PB +: PB], oPacketWr ← 1
  - counter ← 0, go to WAIT
- If no iReq bit is set, stay in IDLE.
- WAIT: oPacketWr ← 0 after its single cycle. Each edge evaluates, in priority order:
  - iPacketErr=1 → oErr ← oGrant, go to RESP.
  - iPacketDone=1 → oDone ← oGrant, go to RESP.
  - counter == pTimeout-1 → oErr ← oGrant, go to RESP.
  - otherwise counter ← counter+1.
- RESP: one cycle. oDone/oErr are high during it. At the next edge, oDone, oErr and oGrant ← 0, go to IDLE.
- Requester contract: drop iReq at the edge that ends its oDone/oErr cycle. IDLE does not re-arbitrate until that edge has passed.
- iPacketDone/iPacketErr are ignored in IDLE and RESP.
- iReq changes during WAIT/RESP do not affect the current transfer.

## Timing
- Request to strobe: iReq[k] sampled high in IDLE at edge E0 → oGrant and oPacketData valid and oPacketWr=1 from E0 to E1 (1 cycle).
- Done to response: iPacketDone sampled at edge Ed → oDone high for exactly one cycle after Ed. oGrant and oBusy fall at Ed+1.
- Back-to-back grant: earliest next oPacketWr is 2 cycles after the oDone cycle begins (RESP → IDLE → grant).
- Simultaneous iPacketErr and iPacketDone: only oErr pulses.
- Done arriving on the timeout cycle: oDone is reported, not oErr.
- Timeout: with no response, oErr is set at the pTimeout-th WAIT edge after entry.
- Reset mid-transfer: outputs clear at the first reset edge. A late iPacketDone after reset is ignored. The pointer is restored, so requester 0 wins first.

## Test plan
- Reset: iRst=0 for 2 cycles with iReq=2'b11 and iPacketDone toggling → every output stays 0, with no oPacketWr pulse.
- Single request: iReq=2'b10 with packet bytes 0x00..0x3F; iPacketDone returned 10 cycles after the strobe → oGrant=2'b10, exactly one oPacketWr cycle, oPacketData equals the packet, oDone=2'b10 for one cycle, then oGrant=0.
- Fairness: iReq=2'b11 held, with requesters re-asserting after each oDone, for 4 packets → grant order 01, 10, 01, 10; oPacketData matches the owner each time.
- Error priority: iPacketErr=1 alone → oErr pulse on the owner, oDone stays 0. iPacketErr=1 and iPacketDone=1 in the same cycle → oErr only.
- Timeout: pTimeout=16, no response → oErr pulses 16 cycles after entering WAIT, oBusy drops 1 cycle later, and a pending request is granted next.
- Reset mid-WAIT: assert iRst=0 4 cycles after the strobe, then pulse iPacketDone after release → no oDone/oErr. With iReq=2'b11, the first post-reset grant is 2'b01.
